gf2_poly_div_seq: RTL
=====================

Name: gf2_poly_div_seq

Overview:
- Sequential carry-less (GF(2)) polynomial divider. It is the inverse of the Karatsuba carry-less multiplier datapath.
- It takes a (2N-1)-bit product as dividend and a degree-N divisor polynomial, then returns the quotient and remainder.
- It processes one dividend bit per cycle.
- It sits downstream of the overlap/recombine stage, so the multiplier plus divider form a GF(2^N) mod-reduce chain. It also serves as a self-check path for multiplier results.

Parameters:
- N, 8, operand width. The dividend is 2N-1 bits, the divisor N+1 bits, the quotient N-1 bits, the remainder N bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  dividend/divisor presented
- in_ready  out  1  block can accept a new operation
- in_dividend  in  2N-1  dividend polynomial, bit i is the coefficient of x^i
- in_poly  in  N+1  divisor polynomial; in_poly[N] must be 1
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_quot  out  N-1  quotient polynomial
- out_rem  out  N  remainder polynomial
- out_err  out  1  divisor invalid (in_poly[N]==0)

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, out_quot=0, out_rem=0, out_err=0. Reset applies on any cycle, including mid-RUN or DONE; any in-flight operation is discarded with no output.
- All arithmetic is GF(2): addition/subtraction is XOR, with no carries anywhere.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&in_ready, latch work=in_dividend and div=in_poly, clear quot, set cnt=N-2.
    - If in_poly[N]==1, go to RUN.
    - If in_poly[N]==0, go directly to DONE with out_err=1, out_quot=0, out_rem=0.
  - RUN: in_ready=0. Each cycle, examine bit k=N+cnt of work.
    - If work[k]==1: work ^= div<<cnt and quot[cnt]=1. Otherwise quot[cnt]=0.
    - If cnt==0, go to DONE; else cnt-=1.
    - RUN lasts exactly N-1 cycles.
  - DONE: out_valid=1, out_quot=quot, out_rem=work[N-1:0], out_err as latched.
    - Outputs stay stable while out_ready=0.
    - On out_valid&out_ready, go to IDLE; out_valid drops the next cycle.
- Latency: an input handshake on edge t gives out_valid=1 from cycle t+N (N-1 RUN cycles plus one transition). The error path gives out_valid at t+1.
- Throughput: at most one operation per N+1 cycles. in_ready reasserts the cycle after the output handshake. There is no input/output overlap: in_ready=0 in RUN and DONE.
- in_dividend and in_poly are sampled only at the input handshake. Changes on them afterwards have no effect.
- Upper work bits [2N-2:N] are zero at the end of RUN by construction. The verifier must check this.
- out_quot and out_rem hold their last values in IDLE. Only out_valid qualifies them.

Decomposition:
- Shared package gf2_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - constant GF2_AES_POLY = 9'h11B (for N=8)
  - the width helper functions for the dividend (2N-1), quotient (N-1) and remainder (N)
- One natural sub-module, gf2_div_step. It is purely combinational: given work, div and cnt, it returns the next work value and the quotient bit. The FSM, counter and handshake stay in the top module.

Test Plan:
- Dividend 0x2B79 (= 0x57 ⊗ 0x83), poly 0x11B -> out_valid at t+8, out_quot=0x28, out_rem=0xC1, out_err=0.
- Dividend 0x00FF, poly 0x11B -> out_quot=0x00, out_rem=0xFF. Dividend 0x0000 -> quot 0, rem 0.
- Poly 0x01B (MSB clear), dividend 0x1234 -> out_valid at t+1, out_err=1, quot=0, rem=0. The next op with poly 0x11B must return out_err=0.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid, out_quot and out_rem stable, in_ready=0. Raise out_ready -> in_ready=1 the next cycle. Back-to-back ops complete every 9 cycles.
- Assert rst for one cycle at RUN cycle 3, then release -> IDLE, in_ready=1, out_valid=0, and no stale result. A fresh op 0x2B79/0x11B must still give 0x28/0xC1.
- Random sweep of 1000 dividends with poly 0x11B -> the scoreboard must satisfy (quot ⊗ poly) ^ rem == dividend and deg(rem) < 8.

Source files
------------

// File: rtl/gf2_pkg.sv
// Shared types and width helpers for the GF(2) polynomial divider.
package gf2_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [8:0] GF2_AES_POLY = 9'h11B;

  function automatic int dividend_w(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int quot_w(input int n);
    return n - 1;
  endfunction

  function automatic int rem_w(input int n);
    return n;
  endfunction

  // Counter must hold N-2; keep at least one bit for tiny N.
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n - 1) : 1;
  endfunction

endpackage

// File: rtl/gf2_div_step.sv
// One long-division step: test bit N+cnt of work and cancel it with div<<cnt.
module gf2_div_step
  import gf2_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [dividend_w(N)-1:0] work_i,
  input  logic [N:0]               div_i,
  input  logic [cnt_w(N)-1:0]      cnt_i,
  output logic [dividend_w(N)-1:0] work_o,
  output logic                     qbit_o
);

  localparam int DW = dividend_w(N);
  localparam int KW = $clog2(DW);

  logic [DW-1:0] div_ext;
  logic [KW-1:0] k;

  always_comb begin
    div_ext       = '0;
    div_ext[N:0]  = div_i;
    k             = KW'(N) + KW'(cnt_i);
    qbit_o        = work_i[k];
    work_o        = qbit_o ? (work_i ^ (div_ext << cnt_i)) : work_i;
  end

endmodule

// File: rtl/gf2_poly_div_seq.sv
// Sequential carry-less divider: one dividend bit per RUN cycle, valid/ready at both ends.
module gf2_poly_div_seq
  import gf2_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [dividend_w(N)-1:0] in_dividend,
  input  logic [N:0]               in_poly,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [quot_w(N)-1:0]     out_quot,
  output logic [rem_w(N)-1:0]      out_rem,
  output logic                     out_err
);

  localparam int DW = dividend_w(N);
  localparam int QW = quot_w(N);
  localparam int RW = rem_w(N);
  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] CNT_START = CW'(N - 2);

  state_t        state_q;
  logic [DW-1:0] work_q;
  logic [N:0]    div_q;
  logic [QW-1:0] quot_q;
  logic [CW-1:0] cnt_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [QW-1:0] out_quot_q;
  logic [RW-1:0] out_rem_q;
  logic          out_err_q;

  logic [DW-1:0] work_d;
  logic          qbit_d;
  logic [QW-1:0] quot_d;

  gf2_div_step #(.N(N)) u_step (
    .work_i (work_q),
    .div_i  (div_q),
    .cnt_i  (cnt_q),
    .work_o (work_d),
    .qbit_o (qbit_d)
  );

  always_comb begin
    quot_d        = quot_q;
    quot_d[cnt_q] = qbit_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      work_q      <= '0;
      div_q       <= '0;
      quot_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_quot_q  <= '0;
      out_rem_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q     <= in_dividend;
            div_q      <= in_poly;
            quot_q     <= '0;
            cnt_q      <= CNT_START;
            in_ready_q <= 1'b0;
            if (in_poly[N]) begin
              state_q   <= RUN;
              out_err_q <= 1'b0;
            end else begin
              // A divisor without its leading term cannot be divided by; report immediately.
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_err_q   <= 1'b1;
              out_quot_q  <= '0;
              out_rem_q   <= '0;
            end
          end
        end
        RUN: begin
          work_q <= work_d;
          quot_q <= quot_d;
          if (cnt_q == '0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_quot_q  <= quot_d;
            out_rem_q   <= work_d[RW-1:0];
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_quot  = out_quot_q;
  assign out_rem   = out_rem_q;
  assign out_err   = out_err_q;

endmodule
